// File: rtl/sr_latch_bank_arbiter.sv
// rtl/sr_latch_bank_arbiter.sv - round-robin arbiter sequencing a shared gated SR latch bank
// Requests are served one at a time: SETUP drives S/R, PULSE raises En, HOLD checks Q.
module sr_latch_bank_arbiter #(
  parameter int NREQ      = 4,
  parameter int W         = 8,
  parameter int PULSE_CYC = 1,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*W-1:0] req_mask,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      latch_s,
  output logic [W-1:0]      latch_r,
  output logic              latch_en,
  input  logic [W-1:0]      q_in,
  output logic              busy,
  output logic [IW-1:0]     grant_id,
  output logic              err
);

  localparam int CW = $clog2(PULSE_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic          op_q;
  logic [W-1:0]  mask_q;
  logic          any;
  logic [IW-1:0] pick;

  // First valid requester strictly after the last grant, wrapping around.
  always_comb begin
    any  = 1'b0;
    pick = '0;
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NREQ;
      if (!any && req_valid[idx]) begin
        any  = 1'b1;
        pick = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IW'(NREQ - 1);
      cnt       <= '0;
      op_q      <= 1'b0;
      mask_q    <= '0;
      req_ready <= '0;
      latch_s   <= '0;
      latch_r   <= '0;
      latch_en  <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= '0;
      err       <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          latch_s  <= '0;
          latch_r  <= '0;
          latch_en <= 1'b0;
          busy     <= 1'b0;
          if (any) begin
            op_q     <= req_op[pick];
            mask_q   <= req_mask[pick*W +: W];
            ptr      <= pick;
            grant_id <= pick;
            latch_s  <= req_op[pick] ? req_mask[pick*W +: W] : '0;
            latch_r  <= req_op[pick] ? '0 : req_mask[pick*W +: W];
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          latch_en <= 1'b1;
          cnt      <= CW'(PULSE_CYC - 1);
          state    <= PULSE;
        end
        PULSE: begin
          if (cnt == '0) begin
            latch_en            <= 1'b0;
            req_ready[grant_id] <= 1'b1;
            state               <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          // S/R stay applied during this cycle so Q has settled before the compare.
          if ((q_in & mask_q) != (op_q ? mask_q : '0)) err <= 1'b1;
          latch_s <= '0;
          latch_r <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_bank_arbiter.sv
// tb/tb_sr_latch_bank_arbiter.sv - self-checking bench for sr_latch_bank_arbiter
// A behavioural SR latch drives q_in; a spec-level model predicts grants, latch contents and err.
module tb_sr_latch_bank_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int P    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_op = '0;
  logic [NREQ*W-1:0] req_mask = '0;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      latch_s;
  logic [W-1:0]      latch_r;
  logic              latch_en;
  logic [W-1:0]      q_in;
  logic              busy;
  logic [1:0]        grant_id;
  logic              err;

  logic [W-1:0] lq = '0;
  logic         stuck = 1'b0;
  int           total = 0;
  int           bad = 0;
  int           ptr_m;
  logic [W-1:0] mem;
  logic         err_m;

  sr_latch_bank_arbiter #(.NREQ(NREQ), .W(W), .PULSE_CYC(P)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_mask(req_mask),
    .req_ready(req_ready), .latch_s(latch_s), .latch_r(latch_r), .latch_en(latch_en),
    .q_in(q_in), .busy(busy), .grant_id(grant_id), .err(err)
  );

  always #5 clk = ~clk;

  // Level-sensitive gated SR latch; stuck forces the read-back path to zero.
  always @(latch_en or latch_s or latch_r)
    if (latch_en) lq = (lq & ~latch_r) | latch_s;
  assign q_in = stuck ? '0 : lq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_next(input logic [NREQ-1:0] v, input int p);
    for (int i = 1; i <= NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("s_and_r", {24'h0, latch_s & latch_r}, 0);
      if (latch_en) begin
        check("en_busy", {31'h0, busy}, 1);
        check("en_ready", {28'h0, req_ready}, 0);
      end
    end
  end

  // Called at an IDLE-cycle negedge with requests already driven; ends at the next IDLE negedge.
  task automatic serve(input int g, input logic op, input logic [W-1:0] m);
    int n;
    logic [W-1:0] qv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_op[g] = ~req_op[g];
        req_mask[g*W +: W] = W'($urandom);
        if ($urandom_range(1, 0) == 1) req_valid[g] = 1'b0;
      end
    end while (req_ready == '0 && n < 20);
    check("ready_latency", n, P + 2);
    check("ready_onehot", {28'h0, req_ready}, 32'h1 << g);
    check("grant_id", {30'h0, grant_id}, g);
    check("hold_s", {24'h0, latch_s}, op ? {24'h0, m} : 0);
    check("hold_r", {24'h0, latch_r}, op ? 0 : {24'h0, m});
    check("hold_en", {31'h0, latch_en}, 0);
    req_valid[g] = 1'b0;
    mem = op ? (mem | m) : (mem & ~m);
    qv = stuck ? '0 : mem;
    if ((qv & m) != (op ? m : '0)) err_m = 1'b1;
    ptr_m = g;
    @(negedge clk);
    check("idle_busy", {31'h0, busy}, 0);
    check("idle_ready", {28'h0, req_ready}, 0);
    check("idle_sr", {24'h0, latch_s | latch_r}, 0);
    check("q_readback", {24'h0, q_in}, {24'h0, qv});
    check("err", {31'h0, err}, {31'h0, err_m});
  endtask

  initial begin
    mem = '0; err_m = 1'b0; ptr_m = NREQ - 1;
    repeat (2) @(negedge clk);
    check("rst_s", {24'h0, latch_s}, 0);
    check("rst_r", {24'h0, latch_r}, 0);
    check("rst_en", {31'h0, latch_en}, 0);
    check("rst_ready", {28'h0, req_ready}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_grant", {30'h0, grant_id}, 0);
    check("rst_err", {31'h0, err}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single set, checked cycle by cycle; mid-op op/mask changes must be ignored.
    req_valid = 4'b0001; req_op[0] = 1'b1; req_mask[7:0] = 8'h0F;
    @(negedge clk);
    check("setup_s", {24'h0, latch_s}, 32'h0F);
    check("setup_r", {24'h0, latch_r}, 0);
    check("setup_en", {31'h0, latch_en}, 0);
    check("setup_busy", {31'h0, busy}, 1);
    check("setup_grant", {30'h0, grant_id}, 0);
    req_op[0] = 1'b0; req_mask[7:0] = 8'hF0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      check("pulse_en", {31'h0, latch_en}, 1);
      check("pulse_s", {24'h0, latch_s}, 32'h0F);
      check("pulse_r", {24'h0, latch_r}, 0);
    end
    @(negedge clk);
    check("hold_ready0", {28'h0, req_ready}, 32'h1);
    check("hold_en0", {31'h0, latch_en}, 0);
    check("hold_s0", {24'h0, latch_s}, 32'h0F);
    check("hold_q0", {24'h0, q_in}, 32'h0F);
    req_valid = '0; mem = 8'h0F; ptr_m = 0;
    @(negedge clk);
    check("after_busy", {31'h0, busy}, 0);
    check("after_s", {24'h0, latch_s}, 0);
    check("after_err", {31'h0, err}, 0);

    // Reset during the second En cycle of a reset op on requester 1.
    req_valid = 4'b0010; req_op[1] = 1'b0; req_mask[15:8] = 8'h0C;
    repeat (3) @(negedge clk);
    check("mid_en_before", {31'h0, latch_en}, 1);
    rst = 1'b1;
    #1;
    check("mid_en", {31'h0, latch_en}, 0);
    check("mid_busy", {31'h0, busy}, 0);
    check("mid_sr", {24'h0, latch_s | latch_r}, 0);
    check("mid_ready", {28'h0, req_ready}, 0);
    check("mid_grant", {30'h0, grant_id}, 0);
    mem = mem & ~8'h0C; req_valid = '0; ptr_m = NREQ - 1;
    repeat (2) begin
      @(negedge clk);
      check("mid_no_ready", {28'h0, req_ready}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Round robin from reset: 0,1,2,3 then 0 and 2 re-raised.
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) begin
      req_op[i] = 1'($urandom);
      req_mask[i*W +: W] = W'($urandom);
    end
    begin
      logic [NREQ-1:0] ops;
      logic [NREQ*W-1:0] masks;
      ops = req_op; masks = req_mask;
      for (int k = 0; k < NREQ; k++) serve(k, ops[k], masks[k*W +: W]);
    end
    req_valid = 4'b0101; req_op[0] = 1'b1; req_mask[7:0] = 8'h81; req_op[2] = 1'b0; req_mask[23:16] = 8'h18;
    serve(0, 1'b1, 8'h81);
    serve(2, 1'b0, 8'h18);

    // Stuck read-back: a zero-mask op must not flag, a set of bit 0 must, and err stays.
    stuck = 1'b1;
    req_valid = 4'b1000; req_op[3] = 1'b1; req_mask[31:24] = 8'h00;
    serve(3, 1'b1, 8'h00);
    req_valid = 4'b0010; req_op[1] = 1'b1; req_mask[15:8] = 8'h01;
    serve(1, 1'b1, 8'h01);
    stuck = 1'b0;

    for (int it = 0; it < 40; it++) begin
      int g;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          req_valid[i] = 1'b1;
          req_op[i] = 1'($urandom);
          req_mask[i*W +: W] = ($urandom_range(3, 0) == 0) ? '0 : W'($urandom);
        end
      end
      if (req_valid == '0) req_valid[$urandom_range(NREQ-1, 0)] = 1'b1;
      g = rr_next(req_valid, ptr_m);
      serve(g, req_op[g], req_mask[g*W +: W]);
    end

    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check("final_err_clear", {31'h0, err}, 0);
    rst = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
